// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one 1-bit full adder is stepped LSB first over
// WIDTH cycles, with the carry held in a flop, behind a start/busy/done handshake.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Holds the WIDTH-1 result bits already produced; the newest bit enters at the top.
  logic [WIDTH-2:0] r_sh;
  logic             cy;
  logic [CW-1:0]    cnt;

  logic             fa_sum;
  logic             fa_carry;
  logic [WIDTH-1:0] r_cat;

  // Single shared 1-bit full adder fed from the operand LSBs and the carry flop.
  assign fa_sum   = a_sh[0] ^ b_sh[0] ^ cy;
  assign fa_carry = (a_sh[0] & b_sh[0]) | (cy & (a_sh[0] ^ b_sh[0]));
  assign r_cat    = {fa_sum, r_sh};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      carry <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      cy    <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= op_a;
            b_sh  <= op_b;
            cy    <= c_in;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          r_sh <= r_cat[WIDTH-1:1];
          cy   <= fa_carry;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum   <= r_cat;
            carry <= fa_carry;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed plus random bench for serial_add_ctrl (WIDTH=8) against an
// arithmetic reference: {carry,sum} = a + b + cin.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         c_in = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry;

  int n_vec = 0;
  int n_err = 0;

  // Reference result currently expected on sum/carry outputs.
  logic [W-1:0] ref_sum = '0;
  logic         ref_cy  = 1'b0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .c_in(c_in), .busy(busy), .done(done), .sum(sum), .carry(carry)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Run one operation from IDLE and check latency, busy length, hold and result.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci);
    logic [W:0] full;
    int cycles, busy_cnt;
    logic held_ok, overlap;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    start = 1'b1; op_a = a; op_b = b; c_in = ci;
    tick();
    start = 1'b0;
    op_a = $urandom; op_b = $urandom; c_in = $urandom;
    cycles = 1; busy_cnt = 0; held_ok = 1'b1; overlap = 1'b0;
    while (!done && cycles < 40) begin
      if (busy) busy_cnt++;
      if (sum !== ref_sum || carry !== ref_cy) held_ok = 1'b0;
      if (busy && done) overlap = 1'b1;
      tick();
      cycles++;
    end
    check({tag, "_latency"}, cycles, W + 1);
    check({tag, "_busy_len"}, busy_cnt, W);
    check({tag, "_hold"}, {31'd0, held_ok}, 1);
    check({tag, "_overlap"}, {31'd0, overlap | (busy & done)}, 0);
    check({tag, "_sum"}, {24'd0, sum}, {24'd0, full[W-1:0]});
    check({tag, "_carry"}, {31'd0, carry}, {31'd0, full[W]});
    ref_sum = full[W-1:0];
    ref_cy  = full[W];
    tick();
    check({tag, "_done_1cyc"}, {31'd0, done}, 0);
  endtask

  initial begin
    logic [W:0] full;
    int t, first_done, second_done, n_done, n_busy;
    logic held_ok;

    // Asynchronous reset between clock edges
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_sum", {24'd0, sum}, 0);
    check("rst_carry", {31'd0, carry}, 0);
    tick();
    rst_n = 1'b1;

    // Basic sums and carry-in path
    run_op("z", 8'h00, 8'h00, 1'b0);
    run_op("s7f", 8'h7F, 8'h01, 1'b0);
    run_op("sff", 8'hFF, 8'h01, 1'b0);
    run_op("sa5", 8'hA5, 8'h5A, 1'b1);
    run_op("ci0f", 8'h0F, 8'h00, 1'b1);
    run_op("ciff", 8'hFF, 8'hFF, 1'b1);

    // Start pulsed mid-run with new operands must be ignored
    start = 1'b1; op_a = 8'h12; op_b = 8'h34; c_in = 1'b0;
    tick();
    start = 1'b0;
    tick(); tick();
    start = 1'b1; op_a = 8'hFF; op_b = 8'hFF; c_in = 1'b1;
    tick();
    start = 1'b0;
    t = 4;
    while (!done && t < 40) begin tick(); t++; end
    check("ign_latency", t, W + 1);
    check("ign_sum", {24'd0, sum}, 32'h46);
    check("ign_carry", {31'd0, carry}, 0);
    n_done = 0; n_busy = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (done) n_done++;
      if (busy) n_busy++;
    end
    check("ign_no_second", n_done + n_busy, 0);
    ref_sum = 8'h46; ref_cy = 1'b0;

    // Back-to-back with start held high
    start = 1'b1; op_a = 8'h01; op_b = 8'h02; c_in = 1'b0;
    tick();
    op_a = 8'h03; op_b = 8'h04;
    t = 1; first_done = 0; second_done = 0; held_ok = 1'b1;
    while (second_done == 0 && t < 60) begin
      if (done && first_done == 0) begin
        first_done = t;
        check("b2b_sum1", {24'd0, sum}, 32'h03);
      end else if (done) begin
        second_done = t;
        check("b2b_sum2", {24'd0, sum}, 32'h07);
      end else if (first_done != 0 && sum !== 8'h03) begin
        held_ok = 1'b0;
      end
      if (first_done != 0 && busy) start = 1'b0;
      if (second_done == 0) begin tick(); t++; end
    end
    start = 1'b0;
    check("b2b_first", first_done, W + 1);
    check("b2b_gap", second_done - first_done, W + 2);
    check("b2b_hold", {31'd0, held_ok}, 1);
    tick();
    ref_sum = 8'h07; ref_cy = 1'b0;

    // Reset in the middle of an operation
    start = 1'b1; op_a = 8'hFF; op_b = 8'h01; c_in = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("mid_busy_pre", {31'd0, busy}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_out", {23'd0, carry, sum}, 0);
    tick();
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || busy) n_done++;
    end
    check("mid_no_done", n_done, 0);
    ref_sum = '0; ref_cy = 1'b0;
    run_op("after_rst", 8'h10, 8'h20, 1'b0);

    // Random operands against the arithmetic reference
    for (int i = 0; i < 10; i++) begin
      run_op("rnd", W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial N-bit adder controller. It sequences a single instance of the team's Full_adder cell (ports a, b, c_in, sum, carry) over WIDTH clock cycles, LSB first, and keeps the carry in a flip-flop between bits. It presents a start/busy/done handshake, so the team's datapath blocks can share one 1-bit adder for multi-bit sums.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range is 2 to 32.
- CW, $clog2(WIDTH), width of the bit counter; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- op_a  input  WIDTH  operand A; captured on the accepted start.
- op_b  input  WIDTH  operand B; captured on the accepted start.
- c_in  input  1  carry-in; captured on the accepted start.
- busy  output  1  high while bits are being processed (RUN state).
- done  output  1  one-cycle pulse: result is valid.
- sum  output  WIDTH  registered result; holds until the next completion.
- carry  output  1  registered carry-out of the MSB; holds with sum.

Behaviour:
- States: IDLE, RUN, DONE. Use a registered FSM with a single current-state register.
- Reset (rst_n low, asynchronous, any state):
  - state goes to IDLE;
  - busy=0, done=0, sum=0, carry=0;
  - shift registers, carry flop and counter go to 0.
- Reset release is synchronous to clk. The first start is accepted on the first rising edge with rst_n high.
- IDLE:
  - start=1 at edge E0: a_sh<=op_a, b_sh<=op_b, cy<=c_in, cnt<=0, go to RUN.
  - start=0: stay in IDLE.
- RUN: the Full_adder inputs are a_sh[0], b_sh[0], cy. On each edge:
  - a_sh and b_sh shift right by 1;
  - the FA sum bit shifts into the MSB of r_sh (shift right);
  - cy<=FA carry;
  - cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1 (the last bit):
    - sum<={FA sum, r_sh[WIDTH-1:1]}, i.e. the full result;
    - carry<=FA carry;
    - go to DONE.
- DONE: done=1 for exactly one cycle, then unconditionally go to IDLE.
- Latency: start accepted at E0 gives RUN for edges E1..E(WIDTH), DONE for the cycle after E(WIDTH), and back in IDLE after E(WIDTH+1). Total from start to done = WIDTH+1 cycles.
- busy=1 exactly in RUN (WIDTH cycles). busy and done are never high together.
- start while busy or done is ignored. It is not queued, and op_a/op_b/c_in changes during RUN do not affect the result.
- Back-to-back: a start held high goes IDLE->RUN on the first edge after DONE. Minimum issue interval is WIDTH+2 cycles.
- sum/carry change only on the completion edge. Between completions they hold the previous result, including while the next operation runs.
- Arithmetic: {carry,sum} = op_a + op_b + c_in, computed modulo 2^(WIDTH+1). There is no overflow flag; signed overflow is the caller's job.
- Reset mid-RUN: the operation is abandoned, outputs clear to 0, and no done pulse is produced.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
1. Reset values: assert rst_n=0 asynchronously between edges -> busy=0, done=0, sum=8'h00, carry=0 immediately, without waiting for an edge.
2. Basic sums (WIDTH=8), each checking done high exactly 9 cycles after the start edge and busy high for exactly 8 cycles:
   - 8'h00+8'h00+0 -> sum=8'h00, carry=0;
   - 8'h7F+8'h01+0 -> sum=8'h80, carry=0;
   - 8'hFF+8'h01+0 -> sum=8'h00, carry=1;
   - 8'hA5+8'h5A+1 -> sum=8'h00, carry=1.
3. Carry-in path: 8'h0F+8'h00+1 -> sum=8'h10, carry=0; 8'hFF+8'hFF+1 -> sum=8'hFF, carry=1.
4. Ignored start / operand stability: 8'h12+8'h34+0 started; pulse start with 8'hFF/8'hFF mid-RUN and change the operands -> single done, sum=8'h46, carry=0, no second operation.
5. Back-to-back: hold start=1 with 8'h01+8'h02, then 8'h03+8'h04 -> done pulses 10 cycles apart. The first gives sum=8'h03; it holds through the second RUN, then becomes 8'h07.
6. Reset mid-operation: start 8'hFF+8'h01 and drop rst_n after 4 RUN cycles -> IDLE, outputs 0, no done. A new start after release, 8'h10+8'h20, gives sum=8'h30, carry=0.
